// File: rtl/layer_sequencer.sv
// Sequencer for one fully-connected layer: buffers an input vector, broadcasts it to the neurons,
// collects their results and drains them in neuron order. Optional argmax via LAYER_SEQ_ARGMAX_EN.
//
// state    | meaning
// S_LOAD   | accepting input words into ibuf (in_ready=1)
// S_STREAM | contiguous n_valid burst of ibuf[0..numInputs-1]
// S_WAIT   | capturing neuron results until every neuron has reported
// S_DRAIN  | presenting obuf[rd_idx] downstream with valid/ready
module layer_sequencer #(
  parameter int numInputs  = 10,
  parameter int numNeurons = 10,
  parameter int dataWidth  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [dataWidth-1:0]             in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [dataWidth-1:0]             n_data,
  output logic                             n_valid,
  input  logic [numNeurons*dataWidth-1:0]  n_out,
  input  logic [numNeurons-1:0]            n_outvalid,
  output logic [dataWidth-1:0]             out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             layer_done
`ifdef LAYER_SEQ_ARGMAX_EN
  ,
  output logic [$clog2(numNeurons)-1:0]    argmax_idx,
  output logic                             argmax_valid
`endif
);

  localparam int IW  = $clog2(numInputs + 1);
  localparam int RW  = $clog2(numNeurons + 1);
  localparam int IAW = (numInputs > 1) ? $clog2(numInputs) : 1;
  localparam int RAW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam logic [IW-1:0] IN_LAST = IW'(numInputs - 1);
  localparam logic [IW-1:0] IN_CNT  = IW'(numInputs);
  localparam logic [RW-1:0] RD_LAST = RW'(numNeurons - 1);

  typedef enum logic [1:0] {S_LOAD, S_STREAM, S_WAIT, S_DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          wr_idx, st_idx;
  logic [RW-1:0]          rd_idx;
  logic [numNeurons-1:0]  got, got_nxt;
  logic [dataWidth-1:0]   ibuf [numInputs];
  logic [dataWidth-1:0]   obuf [numNeurons];
  logic                   in_fire, out_fire;

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = obuf[rd_idx[RAW-1:0]];
    layer_done = 1'b0;
    in_fire    = 1'b0;
    out_fire   = 1'b0;
    busy       = (state != S_LOAD);
    got_nxt    = got | n_outvalid;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        in_fire  = in_valid;
        if (in_valid && wr_idx == IN_LAST) state_nxt = S_STREAM;
      end
      S_STREAM: if (st_idx == IN_CNT) state_nxt = S_WAIT;
      S_WAIT:   if (&got_nxt) state_nxt = S_DRAIN;
      S_DRAIN: begin
        out_valid = 1'b1;
        out_fire  = out_ready;
        if (out_ready && rd_idx == RD_LAST) begin
          layer_done = 1'b1;
          state_nxt  = S_LOAD;
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx  <= '0;
      st_idx  <= '0;
      rd_idx  <= '0;
      got     <= '0;
      n_valid <= 1'b0;
      n_data  <= '0;
    end else begin
      case (state)
        S_LOAD: if (in_valid) begin
          // The first beat launches on the accepting edge, so ibuf[0] may still be in flight.
          if (wr_idx == IN_LAST) begin
            wr_idx  <= '0;
            st_idx  <= IW'(1);
            n_valid <= 1'b1;
            n_data  <= (wr_idx == '0) ? in_data : ibuf[0];
          end else begin
            wr_idx <= wr_idx + IW'(1);
          end
        end
        S_STREAM: begin
          if (st_idx == IN_CNT) begin
            st_idx  <= '0;
            n_valid <= 1'b0;
          end else begin
            n_data <= ibuf[st_idx[IAW-1:0]];
            st_idx <= st_idx + IW'(1);
          end
        end
        S_WAIT: got <= got_nxt;
        S_DRAIN: if (out_ready) begin
          if (rd_idx == RD_LAST) begin
            rd_idx <= '0;
            got    <= '0;
          end else begin
            rd_idx <= rd_idx + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) ibuf[wr_idx[IAW-1:0]] <= in_data;
    if (state == S_WAIT) begin
      for (int i = 0; i < numNeurons; i++)
        if (n_outvalid[i]) obuf[i] <= n_out[i*dataWidth +: dataWidth];
    end
  end

`ifdef LAYER_SEQ_ARGMAX_EN
  logic signed [dataWidth-1:0] max_val;
  logic [RAW-1:0]              max_idx;
  logic                        take;

  // Strict greater-than keeps the lower index on ties.
  assign take         = (rd_idx == '0) || ($signed(out_data) > max_val);
  assign argmax_valid = layer_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_val    <= '0;
      max_idx    <= '0;
      argmax_idx <= '0;
    end else if (out_fire) begin
      if (take) begin
        max_val <= $signed(out_data);
        max_idx <= rd_idx[RAW-1:0];
      end
      if (layer_done) argmax_idx <= take ? rd_idx[RAW-1:0] : max_idx;
    end
  end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomised self-checking bench for layer_sequencer (numInputs=4, numNeurons=3), with a
// behavioural model of the expected burst, drain order and argmax.
`timescale 1ns/1ps
module tb_layer_sequencer;
  localparam int NI = 4;
  localparam int NN = 3;
  localparam int DW = 16;

  typedef logic [DW-1:0] vec_t [NI];

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     n_data;
  logic              n_valid;
  logic [NN*DW-1:0]  n_out;
  logic [NN-1:0]     n_outvalid;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              layer_done;
`ifdef LAYER_SEQ_ARGMAX_EN
  logic [$clog2(NN)-1:0] argmax_idx;
  logic                  argmax_valid;
`endif

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_out [NN];
  int exp_arg;

  layer_sequencer #(.numInputs(NI), .numNeurons(NN), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .n_data(n_data), .n_valid(n_valid),
    .n_out(n_out), .n_outvalid(n_outvalid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .layer_done(layer_done)
`ifdef LAYER_SEQ_ARGMAX_EN
    , .argmax_idx(argmax_idx), .argmax_valid(argmax_valid)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_argmax();
    int b = 0;
    for (int i = 1; i < NN; i++)
      if ($signed(exp_out[i]) > $signed(exp_out[b])) b = i;
    return b;
  endfunction

  task automatic pulse(input logic [NN-1:0] bits, input logic [DW-1:0] v0, v1, v2, input bit live);
    n_out      = {v2, v1, v0};
    n_outvalid = bits;
    if (live) begin
      if (bits[0]) exp_out[0] = v0;
      if (bits[1]) exp_out[1] = v1;
      if (bits[2]) exp_out[2] = v2;
    end
    @(negedge clk);
    n_outvalid = '0;
  endtask

  task automatic load_vec(input vec_t v, input bit gaps, input bit hold);
    for (int i = 0; i < NI; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = v[i];
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL load_ready word %0d: got %b want 1", i, in_ready);
      end
      @(negedge clk);
    end
    if (hold) in_data = 16'hDEAD;
    else      in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL ready_after_load: got %b want 0", in_ready);
    end
  endtask

  task automatic check_burst(input vec_t v);
    for (int i = 0; i < NI; i++) begin
      total++;
      if (n_valid !== 1'b1 || n_data !== v[i]) begin
        bad++; $display("FAIL burst beat %0d: got v=%b d=%h want v=1 d=%h", i, n_valid, n_data, v[i]);
      end
      @(negedge clk);
    end
    total++;
    if (n_valid !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL burst_end: got n_valid=%b busy=%b out_valid=%b want 0 1 0", n_valid, busy, out_valid);
    end
  endtask

  task automatic drain(input int mode, input bit poke);
    int k = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [DW-1:0] held = '0;
    int pat [5] = '{1, 0, 0, 1, 1};
    exp_arg = ref_argmax();
    while (k < NN && cyc < 40) begin
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = (cyc < 5) ? pat[cyc][0] : 1'b1;
      else                out_ready = ($urandom_range(0, 2) != 0);
      if (poke && cyc == 0) begin
        out_ready  = 1'b0;
        n_out      = {3{16'h7777}};
        n_outvalid = '1;
      end
      #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_out[k]) begin
        bad++; $display("FAIL drain word %0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, exp_out[k]);
      end
      if (stalled) begin
        total++;
        if (out_data !== held) begin
          bad++; $display("FAIL stall_hold: got %h want %h", out_data, held);
        end
      end
      if (out_ready) begin
        total++;
        if (layer_done !== (k == NN - 1)) begin
          bad++; $display("FAIL layer_done word %0d: got %b want %b", k, layer_done, (k == NN - 1));
        end
`ifdef LAYER_SEQ_ARGMAX_EN
        total++;
        if (argmax_valid !== (k == NN - 1)) begin
          bad++; $display("FAIL argmax_valid word %0d: got %b want %b", k, argmax_valid, (k == NN - 1));
        end
`endif
        k++;
        stalled = 0;
        if (k == NN) in_valid = 1'b0;
      end else begin
        stalled = 1;
        held    = out_data;
      end
      @(negedge clk);
      n_outvalid = '0;
      cyc++;
    end
    out_ready = 1'b0;
    #1;
    total++;
    if (k != NN) begin
      bad++; $display("FAIL drain_count: got %0d want %0d", k, NN);
    end
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL after_drain: got busy=%b in_ready=%b out_valid=%b want 0 1 0", busy, in_ready, out_valid);
    end
`ifdef LAYER_SEQ_ARGMAX_EN
    total++;
    if (argmax_idx !== exp_arg[$clog2(NN)-1:0]) begin
      bad++; $display("FAIL argmax_idx: got %0d want %0d", argmax_idx, exp_arg);
    end
`endif
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < NI; i++) v[i] = DW'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; n_out = '0; n_outvalid = '0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || n_valid !== 1'b0 || n_data !== '0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || layer_done !== 1'b0) begin
      bad++; $display("FAIL reset_values: got rdy=%b nv=%b nd=%h ov=%b busy=%b ld=%b want 1 0 0000 0 0 0",
                      in_ready, n_valid, n_data, out_valid, busy, layer_done);
    end
`ifdef LAYER_SEQ_ARGMAX_EN
    total++;
    if (argmax_idx !== '0 || argmax_valid !== 1'b0) begin
      bad++; $display("FAIL reset_argmax: got idx=%0d v=%b want 0 0", argmax_idx, argmax_valid);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_load_stream();
    vec_t v = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    load_vec(v, 0, 0);
    check_burst(v);
  endtask

  task automatic test_collect_order();
    pulse(3'b001, 16'h0100, 16'h0, 16'h0, 1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL early_drain: got %b want 0", out_valid);
    end
    pulse(3'b100, 16'h0, 16'h0, 16'h0200, 1);
    pulse(3'b010, 16'h0, 16'h0300, 16'h0, 1);
    drain(0, 0);
  endtask

  task automatic test_stall();
    vec_t v = rand_vec();
    load_vec(v, 0, 0);
    check_burst(v);
    pulse(3'b111, DW'($urandom), DW'($urandom), DW'($urandom), 1);
    drain(1, 0);
  endtask

  task automatic test_reset_mid();
    vec_t v = rand_vec();
    load_vec(v, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (n_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got nv=%b rdy=%b busy=%b want 0 1 0", n_valid, in_ready, busy);
    end
    v = rand_vec();
    load_vec(v, 0, 0);
    check_burst(v);
    pulse(3'b110, 16'h0, DW'($urandom), DW'($urandom), 1);
    pulse(3'b001, DW'($urandom), 16'h0, 16'h0, 1);
    drain(0, 0);
  endtask

  task automatic test_ignore();
    vec_t v = rand_vec();
    load_vec(v, 0, 1);
    check_burst(v);
    pulse(3'b111, DW'($urandom), DW'($urandom), DW'($urandom), 1);
    drain(0, 1);
    v = rand_vec();
    load_vec(v, 1, 0);
    check_burst(v);
    pulse(3'b111, DW'($urandom), DW'($urandom), DW'($urandom), 1);
    drain(2, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      vec_t v = rand_vec();
      bit [NN-1:0] seen = '0;
      int guard = 0;
      pulse(3'($urandom_range(0, 7)), 16'hBAD0, 16'hBAD1, 16'hBAD2, 0);
      load_vec(v, 1, 0);
      check_burst(v);
      while (seen != '1 && guard < 30) begin
        logic [NN-1:0] bits = 3'($urandom_range(0, 7));
        pulse(bits, DW'($urandom), DW'($urandom), DW'($urandom), 1);
        seen |= bits;
        guard++;
        if (seen != '1) begin
          total++;
          if (out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL rand_wait it %0d: got ov=%b busy=%b want 0 1", it, out_valid, busy);
          end
        end
      end
      drain(2, 0);
    end
  endtask

`ifdef LAYER_SEQ_ARGMAX_EN
  task automatic test_argmax();
    vec_t v = rand_vec();
    load_vec(v, 0, 0);
    check_burst(v);
    pulse(3'b111, 16'hFFF0, 16'h0040, 16'h0040, 1);
    drain(0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_load_stream();
    test_collect_order();
    test_stall();
    test_reset_mid();
    test_ignore();
    test_random();
`ifdef LAYER_SEQ_ARGMAX_EN
    test_argmax();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
